// File: rtl/mp_regfile.sv
// ---------------------------------------------------------------------------
// mp_regfile -- multi-lane architectural register file with issue scoreboard
//
// Each of LANES issue lanes has two combinational read ports, one write port
// and one allocate port. The scoreboard keeps one pending bit per register:
// an allocate sets it and a write clears it. If both happen on the same edge,
// the allocate wins. Register 0 is hard-wired to zero and is never pending.
//
// Optional feature: define MP_REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports and to forward the pending-bit clear to rsN_busy.
// Without the macro, reads and busy reflect only pre-edge state.
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   rst       in   asynchronous active-high reset (array and scoreboard to 0)
//   rs1, rs2  in   LANES x AW    source indices per lane
//   rd1, rd2  out  LANES x XLEN  source read data per lane
//   we        in   LANES         write enable per lane
//   wa        in   LANES x AW    write index per lane
//   wd        in   LANES x XLEN  write data per lane
//   alloc_en  in   LANES         mark destination pending per lane
//   alloc_rd  in   LANES x AW    destination index to mark pending
//   rs1_busy, rs2_busy  out  LANES  source operand pending
//   busy_vec  out  NREG          full scoreboard state
// ---------------------------------------------------------------------------
module mp_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int LANES = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANES-1:0][AW-1:0]         rs1,
    input  logic [LANES-1:0][AW-1:0]         rs2,
    output logic [LANES-1:0][XLEN-1:0]       rd1,
    output logic [LANES-1:0][XLEN-1:0]       rd2,
    input  logic [LANES-1:0]                 we,
    input  logic [LANES-1:0][AW-1:0]         wa,
    input  logic [LANES-1:0][XLEN-1:0]       wd,
    input  logic [LANES-1:0]                 alloc_en,
    input  logic [LANES-1:0][AW-1:0]         alloc_rd,
    output logic [LANES-1:0]                 rs1_busy,
    output logic [LANES-1:0]                 rs2_busy,
    output logic [NREG-1:0]                  busy_vec
);

    logic [XLEN-1:0] regs_r     [NREG];
    logic [XLEN-1:0] regs_nxt_s [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [NREG-1:0] wr_tgt_s;     // registers targeted by any enabled write
    logic [NREG-1:0] alloc_tgt_s;  // registers targeted by any allocate

    // Read value for one index; x0 always reads zero.
    function automatic logic [XLEN-1:0] rd_val(input logic [AW-1:0] idx);
        logic [XLEN-1:0] v;
        v = regs_r[idx];
`ifdef MP_REGFILE_BYPASS_EN
        // Ascending lane scan: the highest matching lane is applied last.
        for (int i = 0; i < LANES; i++) begin
            v = (we[i] && (wa[i] == idx)) ? wd[i] : v;
        end
`endif
        return (idx == {AW{1'b0}}) ? {XLEN{1'b0}} : v;
    endfunction

    // Pending bit for one index; busy_r[0] is held at zero.
    function automatic logic busy_val(input logic [AW-1:0] idx);
        logic b;
        b = busy_r[idx];
`ifdef MP_REGFILE_BYPASS_EN
        // A same-cycle write clears the operand unless an allocate re-marks it.
        b = wr_tgt_s[idx] ? alloc_tgt_s[idx] : b;
`endif
        return b;
    endfunction

    // Decode per-register write and allocate targets across all lanes.
    always_comb begin
        wr_tgt_s    = {NREG{1'b0}};
        alloc_tgt_s = {NREG{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            wr_tgt_s[wa[i]]          = wr_tgt_s[wa[i]] | we[i];
            alloc_tgt_s[alloc_rd[i]] = alloc_tgt_s[alloc_rd[i]] | alloc_en[i];
        end
        wr_tgt_s[0]    = 1'b0;
        alloc_tgt_s[0] = 1'b0;
    end

    // Next array state: lanes applied in ascending order so the highest lane wins a collision.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_nxt_s[r] = regs_r[r];
            for (int i = 0; i < LANES; i++) begin
                regs_nxt_s[r] = (we[i] && (wa[i] == AW'(r))) ? wd[i] : regs_nxt_s[r];
            end
        end
        regs_nxt_s[0] = {XLEN{1'b0}};
    end

    // Next scoreboard state: clear on write, then set on allocate (allocate wins).
    always_comb begin
        busy_nxt_s    = (busy_r & ~wr_tgt_s) | alloc_tgt_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Register array and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
            busy_r <= {NREG{1'b0}};
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= regs_nxt_s[r];
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Combinational read ports, forced to zero while reset is asserted.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rd1[i]      = rst ? {XLEN{1'b0}} : rd_val(rs1[i]);
            rd2[i]      = rst ? {XLEN{1'b0}} : rd_val(rs2[i]);
            rs1_busy[i] = rst ? 1'b0 : busy_val(rs1[i]);
            rs2_busy[i] = rst ? 1'b0 : busy_val(rs2[i]);
        end
    end

    assign busy_vec = rst ? {NREG{1'b0}} : busy_r;

endmodule

// File: doc/mp_regfile.md
MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers (power of two, >=2).
REQ-003 Parameter LANES, default 2: issue lanes, each with 2 read ports, 1 write port and 1 allocate port.
REQ-004 Derived constant AW = log2(NREG): register index width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rs1  in  LANES x AW  source-1 index per lane.
REQ-008 rs2  in  LANES x AW  source-2 index per lane.
REQ-009 rd1  out  LANES x XLEN  source-1 read data per lane.
REQ-010 rd2  out  LANES x XLEN  source-2 read data per lane.
REQ-011 we  in  LANES x 1  write enable per lane.
REQ-012 wa  in  LANES x AW  write index per lane.
REQ-013 wd  in  LANES x XLEN  write data per lane.
REQ-014 alloc_en  in  LANES x 1  mark destination pending (issue-time) per lane.
REQ-015 alloc_rd  in  LANES x AW  destination index to mark pending.
REQ-016 rs1_busy, rs2_busy  out  LANES x 1  source operand pending (scoreboard hit).
REQ-017 busy_vec  out  NREG  full scoreboard state.

Function
REQ-018 Register 0 SHALL read 0 at all times; writes and allocates to index 0 are ignored; busy_vec[0] is always 0.
REQ-019 Reads SHALL be combinational from array state (zero read latency).
REQ-020 Writes SHALL commit on the rising clk edge where we[i]=1 and wa[i]!=0.
REQ-021 Write collision, same wa on several lanes in one cycle: the highest-numbered lane SHALL win; lower lanes are dropped.
REQ-022 Scoreboard bit r SHALL be set on the edge where any alloc_en[i]=1 with alloc_rd[i]=r (r!=0).
REQ-023 Scoreboard bit r SHALL be cleared on the edge where any enabled write targets r, unless an allocate to r occurs on the same edge, in which case it SHALL remain set (allocate wins).
REQ-024 rsN_busy[i] SHALL equal busy_vec[rsN[i]] as currently registered, with no bypass of same-cycle allocate or clear.
REQ-025 Writes to a register that is not busy SHALL still commit; the scoreboard never blocks writes.
REQ-026 Out-of-range indices cannot occur (NREG = 2^AW); no error reporting.

Reset
REQ-027 While rst=1, all registers SHALL be 0 and busy_vec SHALL be all-zero, asynchronously and independent of clk.
REQ-028 rd1/rd2 SHALL read 0 and rsN_busy SHALL be 0 while reset is asserted.
REQ-029 Writes and allocates presented on the first edge after rst deasserts SHALL take effect normally.

Configuration
REQ-030 Macro MP_REGFILE_BYPASS_EN: when defined, a read whose index matches an enabled same-cycle write (index !=0) SHALL return that wd, highest matching lane first, and rsN_busy SHALL read 0 for that operand unless a same-cycle allocate hits it.
REQ-031 Without MP_REGFILE_BYPASS_EN, reads and busy SHALL reflect pre-edge state only, per REQ-019 and REQ-024.

Verification
REQ-032 Reset: rst=1 mid-run after writing x5=0xDEAD -> rd1 of x5 reads 0 immediately, busy_vec=0, before any clk edge.
REQ-033 Collision: lane0 wa=7 wd=0x11, lane1 wa=7 wd=0x22, both we=1 -> next cycle x7=0x22.
REQ-034 x0: we=1 wa=0 wd=0xFFFF_FFFF plus alloc_rd=0 -> x0 reads 0 and busy_vec[0]=0.
REQ-035 Scoreboard: alloc x9 at cycle 1 -> rs1_busy=1 at cycle 2; write x9 together with a fresh alloc x9 at cycle 3 -> busy remains 1; write x9 alone at cycle 4 -> busy=0 at cycle 5.
REQ-036 Bypass: write x3=0xABCD and read x3 in the same cycle -> rd1=0xABCD with MP_REGFILE_BYPASS_EN, old value without it.
REQ-037 Parameter sweep: LANES=4, NREG=64, XLEN=64 -> every lane writes a distinct register; all values read back correctly on the next cycle.
